// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock divider run-control block.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    DRAIN
  } ctrl_state_t;

  localparam int unsigned DIV_W_DEF   = 28;
  localparam int unsigned MIN_DIVISOR = 2;

endpackage

// File: rtl/clk_div_core.sv
// Divide counter with wrap detect; registers the slowed clock and the per-period tick.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             count_en,
  input  logic [DIV_W-1:0] div_q,
  output logic             wrap,
  output logic             clock_out,
  output logic             tick_out
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_half;

  assign w_last = div_q - DIV_W'(1);
  assign w_half = div_q >> 1;
  assign wrap   = count_en && (r_cnt == w_last);

  // Counter is pinned at zero whenever counting is disabled, so every run starts a fresh period.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      clock_out <= 1'b0;
      tick_out  <= 1'b0;
    end else begin
      if (!count_en || wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      clock_out <= count_en && (r_cnt < w_half);
      tick_out  <= wrap;
    end
  end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run-control FSM and divisor handshake around clk_div_core.
// Optional tick_count output when CLOCK_DIVIDER_CTRL_TICK_COUNT_EN is defined.
module clock_divider_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned       DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0]  DIVISOR = DIV_W'(8)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clock_out,
  output logic             tick_out,
`ifdef CLOCK_DIVIDER_CTRL_TICK_COUNT_EN
  output logic [15:0]      tick_count,
`endif
  output logic             busy
);

  ctrl_state_t      r_state;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_valid;

  logic w_wrap;
  logic w_count_en;
  logic w_xfer;
  logic w_bad;
  logic w_launch;

  assign w_count_en = (r_state != IDLE);
  assign cfg_ready  = ~r_pend_valid;
  assign w_xfer     = cfg_valid && cfg_ready;
  assign w_bad      = (cfg_divisor < DIV_W'(MIN_DIVISOR));
  assign w_launch   = (r_state == IDLE) && !stop && (start || step);

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .count_en  (w_count_en),
    .div_q     (r_div_q),
    .wrap      (w_wrap),
    .clock_out (clock_out),
    .tick_out  (tick_out)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (stop) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (start) begin
            r_state <= RUN;
            busy    <= 1'b1;
          end else if (step) begin
            r_state <= STEP;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          // A stop landing on the wrap cycle has already finished its period.
          if (stop) begin
            r_state <= w_wrap ? IDLE : DRAIN;
            busy    <= !w_wrap;
          end
        end
        STEP, DRAIN: begin
          if (w_wrap) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // New divisors only take effect at a period boundary (or at once when idle).
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_div_q      <= DIVISOR;
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= w_xfer && w_bad;
      if (w_xfer && !w_bad) begin
        r_pend_div   <= cfg_divisor;
        r_pend_valid <= 1'b1;
      end else if (r_pend_valid && ((r_state == IDLE) || w_wrap)) begin
        r_div_q      <= r_pend_div;
        r_pend_valid <= 1'b0;
      end
    end
  end

`ifdef CLOCK_DIVIDER_CTRL_TICK_COUNT_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= 16'h0000;
    end else if (w_launch) begin
      tick_count <= 16'h0000;
    end else if (w_wrap) begin
      tick_count <= tick_count + 16'h0001;
    end
  end
`else
  logic w_launch_unused;
  assign w_launch_unused = w_launch;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: run, stop/drain, config handshake, step, reset.
module tb_clock_divider_ctrl;
  import clk_div_pkg::*;

  localparam int unsigned DW = 28;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, step, cfg_valid;
  logic [DW-1:0] cfg_divisor;
  logic          cfg_ready, cfg_err, clock_out, tick_out, busy;
`ifdef CLOCK_DIVIDER_CTRL_TICK_COUNT_EN
  logic [15:0]   tick_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  clock_divider_ctrl #(
    .DIV_W   (DW),
    .DIVISOR (DW'(8))
  ) dut (
    .clock_in    (clk),
    .reset_n     (rst_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .cfg_valid   (cfg_valid),
    .cfg_divisor (cfg_divisor),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .clock_out   (clock_out),
    .tick_out    (tick_out),
`ifdef CLOCK_DIVIDER_CTRL_TICK_COUNT_EN
    .tick_count  (tick_count),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int k, input int e_clk, input int e_tick,
                         input int e_busy);
    check_eq($sformatf("%s_clk%0d", tag, k), int'(clock_out), e_clk);
    check_eq($sformatf("%s_tick%0d", tag, k), int'(tick_out), e_tick);
    check_eq($sformatf("%s_busy%0d", tag, k), int'(busy), e_busy);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    cfg_valid = 1'b0; cfg_divisor = '0;
    cyc(); cyc();
    check_eq("rst_clock_out", int'(clock_out), 0);
    check_eq("rst_tick_out", int'(tick_out), 0);
    check_eq("rst_cfg_ready", int'(cfg_ready), 1);
    check_eq("rst_cfg_err", int'(cfg_err), 0);
    check_eq("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    cyc();

    // Free run at divisor 8: 1111 0000, tick every 8 cycles.
    start = 1'b1; cyc(); start = 1'b0;
    check_eq("run_busy0", int'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk_out("run8", k, int'(((k - 1) % 8) < 4), int'(k % 8 == 0), 1);
    end

    // Stop sampled at counter 2: finish period, one tick, then idle.
    for (int k = 17; k <= 25; k++) begin
      cyc();
      chk_out("drain8", k, (k <= 24) ? int'(((k - 1) % 8) < 4) : 0, int'(k == 24),
              int'(k < 24));
      if (k == 18) stop = 1'b1;
      if (k == 19) stop = 1'b0;
    end

    // Divisor 1 is rejected.
    cfg_valid = 1'b1; cfg_divisor = DW'(1);
    cyc(); cfg_valid = 1'b0;
    check_eq("bad_err_pulse", int'(cfg_err), 1);
    check_eq("bad_ready", int'(cfg_ready), 1);
    cyc();
    check_eq("bad_err_clear", int'(cfg_err), 0);

    // Run still uses 8; divisor 4 sent mid-period applies at the next wrap.
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk_out("cfg8", k, int'(((k - 1) % 8) < 4), int'(k % 8 == 0), 1);
      check_eq($sformatf("cfg_ready%0d", k), int'(cfg_ready), int'(k <= 10 || k >= 16));
      if (k == 10) begin cfg_valid = 1'b1; cfg_divisor = DW'(4); end
      if (k == 11) cfg_valid = 1'b0;
    end
    for (int j = 1; j <= 13; j++) begin
      cyc();
      chk_out("run4", j, (j <= 12) ? int'(((j - 1) % 4) < 2) : 0,
              int'(j % 4 == 0 && j <= 12), int'(j < 12));
      if (j == 8) stop = 1'b1;
      if (j == 9) stop = 1'b0;
    end

    // Divisor 5 in idle applies on the next cycle.
    cfg_valid = 1'b1; cfg_divisor = DW'(5);
    cyc(); cfg_valid = 1'b0;
    check_eq("idle_cfg_ready_lo", int'(cfg_ready), 0);
    cyc();
    check_eq("idle_cfg_ready_hi", int'(cfg_ready), 1);

    // Single step at 5: 11000, one tick; held step is ignored while stepping.
    step = 1'b1; cyc();
    check_eq("step_busy0", int'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_out("step5", k, (k <= 5) ? int'(k <= 2) : 0, int'(k == 5), int'(k < 5));
      if (k == 2) step = 1'b0;
    end

    // Start with stop in idle: stop wins.
    start = 1'b1; stop = 1'b1;
    cyc();
    check_eq("ss_busy_a", int'(busy), 0);
    cyc();
    check_eq("ss_busy_b", int'(busy), 0);
    check_eq("ss_clock", int'(clock_out), 0);
    start = 1'b0; stop = 1'b0;

    // Reset mid-run with an update pending.
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    cfg_valid = 1'b1; cfg_divisor = DW'(3);
    cyc(); cfg_valid = 1'b0;
    check_eq("mid_pending_ready", int'(cfg_ready), 0);
    check_eq("mid_clock_hi", int'(clock_out), 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_clock", int'(clock_out), 0);
    check_eq("arst_tick", int'(tick_out), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_ready", int'(cfg_ready), 1);
    check_eq("arst_err", int'(cfg_err), 0);
    cyc(); rst_n = 1'b1;
    cyc();
    check_eq("post_rst_busy", int'(busy), 0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_out("post8", k, int'(((k - 1) % 8) < 4), int'(k == 8), 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
